prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/serdes_prbs_pkg.sv | 26 ++
 rtl/prbs7_lfsr.sv | 43 ++++
 rtl/prbs_checker.sv | 215 +++++++++++++++++++++
 tb/tb_prbs_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_prbs_pkg.sv
// ---------------------------------------------------------------------------
// serdes_prbs_pkg
//   Definitions shared by the receive-side PRBS7 checker and the
//   transmit-side PRBS7 generator:
//     - PRBS7 polynomial order and feedback taps (x^7 + x^6 + 1)
//     - checker FSM state encoding
//     - prbs7_predict(): the next bit implied by a 7-bit history
// ---------------------------------------------------------------------------
package serdes_prbs_pkg;

    localparam int PRBS7_ORDER = 7;
    localparam int PRBS7_TAP_A = 7;
    localparam int PRBS7_TAP_B = 6;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_e;

    // Bit s[TAP-1] holds the bit received TAP bits ago.
    function automatic logic prbs7_predict(input logic [PRBS7_ORDER-1:0] s);
        return s[PRBS7_TAP_A-1] ^ s[PRBS7_TAP_B-1];
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// ---------------------------------------------------------------------------
// prbs7_lfsr
//   PRBS7 history register. On each cycle with advance=1 the register
//   shifts left and load_bit enters at bit 0. pred is the bit the
//   polynomial expects next, given the current history.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset (register -> 0)
//   advance   in   shift enable
//   load_bit  in   bit shifted in when advancing
//   pred      out  predicted next bit
// ---------------------------------------------------------------------------
module prbs7_lfsr
    import serdes_prbs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic advance,
    input  logic load_bit,
    output logic pred
);

    logic [PRBS7_ORDER-1:0] lfsr_q;
    logic [PRBS7_ORDER-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {lfsr_q[PRBS7_ORDER-2:0], load_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pred = prbs7_predict(lfsr_q);

endmodule

// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
//   PRBS7 receive checker. Acquires alignment (SEARCH -> VERIFY -> LOCKED),
//   then counts checked bits and bit errors while locked. Lock is dropped
//   when too many errors land in one loss-of-lock window.
//
//   Handshake: data_in is consumed only on cycles where data_in_valid=1;
//   there is no back-pressure. On invalid cycles every piece of state holds
//   and err_pulse is low. All outputs are registered and reflect a valid
//   bit on the cycle after it is sampled.
//
// Parameters:
//   CNT_W        width of bit_count / err_count
//   LOCK_THRESH  consecutive matches in VERIFY needed to lock
//   LOSS_WIN     valid bits per loss-of-lock window
//   LOSS_ERRS    errors within one window that force a relock
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   data_in        in   recovered bit
//   data_in_valid  in   data_in qualifier
//   clear          in   zero counters and cnt_sat (lock is unaffected)
//   locked         out  high while in LOCKED
//   bit_count      out  valid bits checked while locked (saturating)
//   err_count      out  mismatches while locked (saturating)
//   err_pulse      out  one-cycle strobe per mismatch while locked
//   cnt_sat        out  sticky: a counter has reached all-ones
//   state_dbg      out  current FSM state
// ---------------------------------------------------------------------------
module prbs_checker
    import serdes_prbs_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int LOCK_THRESH = 32,
    parameter int LOSS_WIN    = 128,
    parameter int LOSS_ERRS   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_in_valid,
    input  logic             clear,
    output logic             locked,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_pulse,
    output logic             cnt_sat,
    output prbs_state_e      state_dbg
);

    localparam int FILL_W  = 3;
    localparam int MATCH_W = (LOCK_THRESH > 1) ? $clog2(LOCK_THRESH) : 1;
    localparam int WIN_W   = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int WERR_W  = (LOSS_ERRS > 1) ? $clog2(LOSS_ERRS) : 1;

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(PRBS7_ORDER - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WIN - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_ERRS - 1);

    prbs_state_e        state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               cnt_sat_q, cnt_sat_d;
    logic               err_pulse_q, err_pulse_d;
    logic               locked_q, locked_d;

    logic lfsr_adv;
    logic lfsr_bit;
    logic pred;
    logic mismatch;

    prbs7_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .advance  (lfsr_adv),
        .load_bit (lfsr_bit),
        .pred     (pred)
    );

    assign mismatch = data_in ^ pred;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        cnt_sat_d   = cnt_sat_q;
        err_pulse_d = 1'b0;
        lfsr_adv    = 1'b0;
        lfsr_bit    = data_in;

        if (data_in_valid) begin
            lfsr_adv = 1'b1;
            case (state_q)
                ST_SEARCH: begin
                    // Seven received bits fully seed the history register.
                    if (fill_q == FILL_LAST) begin
                        state_d = ST_VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end

                ST_VERIFY: begin
                    if (!mismatch) begin
                        if (match_q == MATCH_LAST) begin
                            state_d   = ST_LOCKED;
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        state_d = ST_SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                    end
                end

                ST_LOCKED: begin
                    // Free-run on the prediction so a received error does
                    // not corrupt the following predictions.
                    lfsr_bit = pred;

                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end

                    if (mismatch && (win_err_q == WERR_LAST)) begin
                        state_d   = ST_SEARCH;
                        fill_d    = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        // Window wrap: the error tally starts afresh.
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = win_err_q + WERR_W'(mismatch);
                    end
                end

                default: begin
                    state_d = ST_SEARCH;
                    fill_d  = '0;
                    match_d = '0;
                end
            endcase
        end

        cnt_sat_d = cnt_sat_q | (&bit_cnt_d) | (&err_cnt_d);

        // clear outranks counting of the same-cycle bit; FSM and LFSR
        // still advance above.
        if (clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
            cnt_sat_d = 1'b0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            cnt_sat_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            cnt_sat_q   <= cnt_sat_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;
    assign err_pulse = err_pulse_q;
    assign cnt_sat   = cnt_sat_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker
//   Two checkers share every input: a default one (CNT_W=32) and a narrow
//   one (CNT_W=4) that saturates. The driver issues directed bit streams
//   from a PRBS7 generator and pushes hand-derived expected values into a
//   queue; the monitor pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_prbs_checker;
    import serdes_prbs_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data_in = 1'b0;
    logic data_in_valid = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic        b_locked, b_err_pulse, b_cnt_sat;
    logic [31:0] b_bit_count, b_err_count;
    prbs_state_e b_state;
    logic        s_locked, s_err_pulse, s_cnt_sat;
    logic [3:0]  s_bit_count, s_err_count;
    prbs_state_e s_state;

    prbs_checker u_big (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .clear         (clear),
        .locked        (b_locked),
        .bit_count     (b_bit_count),
        .err_count     (b_err_count),
        .err_pulse     (b_err_pulse),
        .cnt_sat       (b_cnt_sat),
        .state_dbg     (b_state)
    );

    prbs_checker #(.CNT_W(4)) u_small (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .clear         (clear),
        .locked        (s_locked),
        .bit_count     (s_bit_count),
        .err_count     (s_err_count),
        .err_pulse     (s_err_pulse),
        .cnt_sat       (s_cnt_sat),
        .state_dbg     (s_state)
    );

    // ---------------- scoreboard ----------------
    localparam int K_B_LOCK = 0, K_B_BITS = 1, K_B_ERRS = 2, K_B_SAT = 3;
    localparam int K_S_LOCK = 4, K_S_BITS = 5, K_S_ERRS = 6, K_S_SAT = 7;
    localparam int K_RISE = 8, K_PHI = 9, K_PRISE = 10;

    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int   bit_idx = 0;   // valid bits driven so far
    int   rise_idx = -1; // bit_idx at the most recent rising edge of b_locked
    int   pulse_hi = 0;  // cycles with b_err_pulse high
    int   pulse_rise = 0;
    logic locked_prev = 1'b0;
    logic pulse_prev = 1'b0;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_B_LOCK: return 32'(b_locked);
            K_B_BITS: return b_bit_count;
            K_B_ERRS: return b_err_count;
            K_B_SAT:  return 32'(b_cnt_sat);
            K_S_LOCK: return 32'(s_locked);
            K_S_BITS: return 32'(s_bit_count);
            K_S_ERRS: return 32'(s_err_count);
            K_S_SAT:  return 32'(s_cnt_sat);
            K_RISE:   return 32'(rise_idx);
            K_PHI:    return 32'(pulse_hi);
            K_PRISE:  return 32'(pulse_rise);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    always @(negedge clk) begin
        if (b_err_pulse) pulse_hi++;
        if (b_err_pulse && !pulse_prev) pulse_rise++;
        pulse_prev = b_err_pulse;
        if (b_locked && !locked_prev) rise_idx = bit_idx;
        locked_prev = b_locked;
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] a;
            int          k;
            string       nm;
            e  = exp_q.pop_front();
            k  = kind_q.pop_front();
            nm = name_q.pop_front();
            a  = actual(k);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got %0d, expected %0d", nm, a, e);
            end
        end
    end

    task automatic expect_v(input int kind, input int val, input string name);
        exp_q.push_back(32'(val));
        kind_q.push_back(kind);
        name_q.push_back(name);
    endtask

    // ---------------- driver ----------------
    logic [6:0] gen = 7'h7F;

    task automatic next_gen(output logic b);
        b   = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
    endtask

    task automatic drive(input logic b, input logic v, input logic clr);
        data_in       = b;
        data_in_valid = v;
        clear         = clr;
        @(posedge clk);
        #1;
        if (v) bit_idx++;
        data_in_valid = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        gen = 7'h7F;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic send_prbs(input int n, input logic inv);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_gen(b);
            drive(b ^ inv, 1'b1, 1'b0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int   start;
        logic b;

        do_reset();
        expect_v(K_B_LOCK, 0, "reset_locked");
        expect_v(K_B_BITS, 0, "reset_bit_count");
        expect_v(K_B_ERRS, 0, "reset_err_count");
        expect_v(K_B_SAT,  0, "reset_cnt_sat");
        expect_v(K_S_SAT,  0, "reset_small_cnt_sat");
        @(negedge clk);

        // Clean stream: lock after 7 fill + 32 verify bits; 161 bits counted.
        start = bit_idx;
        send_prbs(200, 1'b0);
        expect_v(K_RISE,   start + 39, "clean_lock_bit");
        expect_v(K_B_LOCK, 1, "clean_locked");
        expect_v(K_B_BITS, 161, "clean_bit_count");
        expect_v(K_B_ERRS, 0, "clean_err_count");
        expect_v(K_B_SAT,  0, "clean_cnt_sat");
        expect_v(K_S_BITS, 15, "small_bit_count_sat");
        expect_v(K_S_SAT,  1, "small_cnt_sat_set");
        expect_v(K_S_LOCK, 1, "small_locked");

        // clear together with a valid bit: counters zero, bit not counted.
        next_gen(b);
        drive(b, 1'b1, 1'b1);
        expect_v(K_B_BITS, 0, "clear_bit_count");
        expect_v(K_B_ERRS, 0, "clear_err_count");
        expect_v(K_B_LOCK, 1, "clear_keeps_lock");
        expect_v(K_S_BITS, 0, "small_clear_bit_count");
        expect_v(K_S_SAT,  0, "small_clear_cnt_sat");
        expect_v(K_S_LOCK, 1, "small_clear_keeps_lock");

        // Three isolated errors while locked.
        for (int i = 0; i < 60; i++) begin
            next_gen(b);
            drive(b ^ ((i == 10) || (i == 30) || (i == 50)), 1'b1, 1'b0);
        end
        expect_v(K_B_BITS, 60, "iso_bit_count");
        expect_v(K_B_ERRS, 3, "iso_err_count");
        expect_v(K_B_LOCK, 1, "iso_locked");
        expect_v(K_PHI,    3, "iso_pulse_cycles");
        expect_v(K_PRISE,  3, "iso_pulse_strobes");
        expect_v(K_S_BITS, 15, "small_iso_bit_count");
        expect_v(K_S_ERRS, 3, "small_iso_err_count");
        @(negedge clk);

        // Error burst: 16th error (window position 33..48) drops lock.
        do_reset();
        send_prbs(200, 1'b0);
        send_prbs(16, 1'b1);
        expect_v(K_B_LOCK, 0, "burst_lock_lost");
        expect_v(K_B_ERRS, 16, "burst_err_count");
        expect_v(K_B_BITS, 177, "burst_bit_count");
        send_prbs(4, 1'b1);
        // Fill = 4 inverted + 3 clean; clean bits 4..6 match (both taps
        // inverted), bit 7 mismatches; fresh fill 8..14, verify 15..46.
        start = bit_idx;
        send_prbs(60, 1'b0);
        expect_v(K_RISE,   start + 46, "burst_relock_bit");
        expect_v(K_B_LOCK, 1, "burst_relocked");
        expect_v(K_B_ERRS, 16, "burst_err_count_after");
        expect_v(K_PHI,    19, "burst_pulse_cycles");
        @(negedge clk);

        // Valid toggling every cycle: same outcome as the clean stream.
        do_reset();
        start = bit_idx;
        for (int i = 0; i < 200; i++) begin
            next_gen(b);
            drive(b, 1'b1, 1'b0);
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        expect_v(K_RISE,   start + 39, "toggle_lock_bit");
        expect_v(K_B_BITS, 161, "toggle_bit_count");
        expect_v(K_B_ERRS, 0, "toggle_err_count");
        expect_v(K_PHI,    19, "toggle_no_pulses");
        @(negedge clk);

        // Mismatch on the 32nd verify bit (match count 31).
        do_reset();
        send_prbs(38, 1'b0);
        send_prbs(1, 1'b1);
        expect_v(K_B_LOCK, 0, "verify_fail_no_lock");
        expect_v(K_B_BITS, 0, "verify_fail_bit_count");
        start = bit_idx;
        send_prbs(45, 1'b0);
        expect_v(K_RISE,   start + 39, "verify_fail_relock_bit");
        expect_v(K_B_BITS, 6, "verify_fail_bit_count_after");
        expect_v(K_B_ERRS, 0, "verify_fail_err_count");

        // Reset mid-lock wins over clear and valid.
        send_prbs(4, 1'b0);
        expect_v(K_B_BITS, 10, "pre_rst_bit_count");
        rst = 1'b1;
        next_gen(b);
        drive(b, 1'b1, 1'b1);
        rst = 1'b0;
        expect_v(K_B_LOCK, 0, "rst_mid_lock_locked");
        expect_v(K_B_BITS, 0, "rst_mid_lock_bit_count");
        expect_v(K_S_LOCK, 0, "rst_mid_lock_small_locked");

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
